sdram_arbiter: RTL and testbench

Shares one SDRAM controller command port (sdram_ctrl_if "sub" side) between NUM_REQ requesters, each presenting a sdram_ctrl_if "man"-style port. Arbitration is round-robin, with one command granted at a time. An in-order tag FIFO records which requester issued each outstanding read, so read data returns to the right requester. The block sits between the CPU/DMA/video masters and the SDRAM controller.

---
 rtl/sdram_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port between NUM_REQ requesters.
// An in-order tag FIFO remembers the owner of every outstanding read so responses route back.
module sdram_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WORD_LEN        = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ*WORD_LEN-1:0]      req_wr,
  input  logic [NUM_REQ-1:0]               req_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_write_data,
  output logic [NUM_REQ-1:0]               req_rdy,
  output logic [NUM_REQ-1:0]               req_rvalid,
  output logic [NUM_REQ-1:0]               req_error,
  output logic [DATA_WIDTH-1:0]            req_read_data,
  output logic [WORD_LEN-1:0]              mem_wr,
  output logic                             mem_rd,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_write_data,
  input  logic                             mem_rdy,
  input  logic                             mem_rvalid,
  input  logic                             mem_error,
  input  logic [DATA_WIDTH-1:0]            mem_read_data,
  output logic                             orphan_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [IDX_W-1:0]     gnt_r;
  logic [IDX_W-1:0]     gnt_nxt_s;
  logic [IDX_W-1:0]     rr_ptr_r;
  logic [IDX_W-1:0]     pick_s;
  logic                 pick_vld_s;
  logic [NUM_REQ-1:0]   active_s;

  logic [WORD_LEN-1:0]  gnt_wr_s;
  logic                 gnt_rd_s;
  logic                 rd_blocked_s;
  logic                 accept_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 empty_s;

  logic [IDX_W-1:0]     tag_mem_r [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 orphan_err_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Per-requester activity decode and FIFO status
  always_comb begin
    active_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      active_s[i] = (|req_wr[i*WORD_LEN +: WORD_LEN]) | req_rd[i];
    end
    full_s  = (count_r == CNT_W'(MAX_OUTSTANDING));
    empty_s = (count_r == CNT_W'(0));
  end

  // Round-robin search; descending loop so the nearest index after rr_ptr wins
  always_comb begin
    pick_s     = '0;
    pick_vld_s = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (active_s[IDX_W'((int'(rr_ptr_r) + k) % NUM_REQ)]) begin
        pick_s     = IDX_W'((int'(rr_ptr_r) + k) % NUM_REQ);
        pick_vld_s = 1'b1;
      end else begin
        pick_s     = pick_s;
      end
    end
  end

  // Granted requester's command view; a write takes priority over a simultaneous read
  always_comb begin
    gnt_wr_s     = req_wr[int'(gnt_r)*WORD_LEN +: WORD_LEN];
    gnt_rd_s     = req_rd[gnt_r] & ~(|gnt_wr_s);
    rd_blocked_s = gnt_rd_s & full_s;
    accept_s     = (state_r == GRANT) & active_s[gnt_r] & mem_rdy & ~rd_blocked_s;
    push_s       = accept_s & gnt_rd_s;
    pop_s        = mem_rvalid & ~empty_s;
  end

  // FSM state and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      gnt_r    <= '0;
      rr_ptr_r <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_r <= state_nxt_s;
      gnt_r   <= gnt_nxt_s;
      if (accept_s) begin
        rr_ptr_r <= gnt_r;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Next-state logic; a withdrawn request releases the grant without moving rr_ptr
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt_r;
    case (state_r)
      IDLE: begin
        if (pick_vld_s) begin
          state_nxt_s = GRANT;
          gnt_nxt_s   = pick_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (accept_s || !active_s[gnt_r]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: command mux in GRANT, response routing by FIFO head
  always_comb begin
    mem_wr         = '0;
    mem_rd         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    req_rdy        = '0;
    req_rvalid     = '0;
    req_error      = '0;
    req_read_data  = mem_read_data;
    orphan_err     = orphan_err_r;
    case (state_r)
      GRANT: begin
        mem_wr         = gnt_wr_s;
        mem_rd         = gnt_rd_s & ~full_s;
        mem_addr       = req_addr[int'(gnt_r)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_write_data = req_write_data[int'(gnt_r)*DATA_WIDTH +: DATA_WIDTH];
        req_rdy[gnt_r] = accept_s;
      end
      IDLE:    mem_rd = 1'b0;
      default: mem_rd = 1'b0;
    endcase
    if (pop_s) begin
      req_rvalid[tag_mem_r[rd_ptr_r]] = 1'b1;
      req_error[tag_mem_r[rd_ptr_r]]  = mem_error;
    end else begin
      req_rvalid = '0;
    end
  end

  // Read-owner tag FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= gnt_r;
        wr_ptr_r            <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for a response with no recorded owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orphan_err_r <= 1'b0;
    end else if (mem_rvalid && empty_s) begin
      orphan_err_r <= 1'b1;
    end else begin
      orphan_err_r <= orphan_err_r;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed plus randomized bench for sdram_arbiter, checked every cycle against a
// transaction-level model (pending-grant owner, round-robin last-served, owner queue).
module tb_sdram_arbiter;

  localparam int N    = 2;
  localparam int WL   = 4;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*WL-1:0] req_wr = '0;
  logic [N-1:0]    req_rd = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N*32-1:0] req_write_data = '0;
  logic [N-1:0]    req_rdy;
  logic [N-1:0]    req_rvalid;
  logic [N-1:0]    req_error;
  logic [31:0]     req_read_data;
  logic [WL-1:0]   mem_wr;
  logic            mem_rd;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_write_data;
  logic            mem_rdy = 1'b0;
  logic            mem_rvalid = 1'b0;
  logic            mem_error = 1'b0;
  logic [31:0]     mem_read_data = '0;
  logic            orphan_err;

  sdram_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .WORD_LEN(WL), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_wr(req_wr), .req_rd(req_rd), .req_addr(req_addr), .req_write_data(req_write_data),
    .req_rdy(req_rdy), .req_rvalid(req_rvalid), .req_error(req_error), .req_read_data(req_read_data),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_rdy(mem_rdy), .mem_rvalid(mem_rvalid), .mem_error(mem_error), .mem_read_data(mem_read_data),
    .orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit m_pend;
  int m_own;
  int m_last;
  bit m_orphan;
  int q[$];
  logic [WL-1:0] e_wr;
  logic          e_rd;
  logic [31:0]   e_addr, e_wd;
  logic [N-1:0]  e_rdy, e_rv, e_er;
  bit            e_acc, e_push;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit act(input int i);
    return (req_wr[i*WL +: WL] != '0) || req_rd[i];
  endfunction

  task automatic m_reset();
    m_pend   = 1'b0;
    m_own    = 0;
    m_last   = N - 1;
    m_orphan = 1'b0;
    q.delete();
  endtask

  // Let inputs settle, compute expected outputs from the model and compare
  task automatic settle_check();
    bit isrd, blocked;
    #1;
    e_wr = '0; e_rd = 1'b0; e_addr = '0; e_wd = '0; e_rdy = '0;
    e_acc = 1'b0; e_push = 1'b0; e_rv = '0; e_er = '0;
    if (m_pend) begin
      e_wr    = req_wr[m_own*WL +: WL];
      isrd    = req_rd[m_own] && (e_wr == '0);
      blocked = isrd && (q.size() == MAXO);
      e_rd    = isrd && !blocked;
      e_addr  = req_addr[m_own*32 +: 32];
      e_wd    = req_write_data[m_own*32 +: 32];
      e_acc   = act(m_own) && mem_rdy && !blocked;
      e_push  = e_acc && isrd;
      if (e_acc) e_rdy[m_own] = 1'b1;
    end
    if (mem_rvalid && q.size() > 0) begin
      e_rv[q[0]] = 1'b1;
      e_er[q[0]] = mem_error;
    end
    chk("mem_wr", 64'(mem_wr), 64'(e_wr));
    chk("mem_rd", 64'(mem_rd), 64'(e_rd));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_write_data", 64'(mem_write_data), 64'(e_wd));
    chk("req_rdy", 64'(req_rdy), 64'(e_rdy));
    chk("req_rvalid", 64'(req_rvalid), 64'(e_rv));
    chk("req_error", 64'(req_error), 64'(e_er));
    chk("req_read_data", 64'(req_read_data), 64'(mem_read_data));
    chk("orphan_err", 64'(orphan_err), 64'(m_orphan));
  endtask

  // Advance the model by one clock and move to just after the next edge
  task automatic advance();
    bit found;
    if (m_pend) begin
      if (e_acc || !act(m_own)) m_pend = 1'b0;
      if (e_acc) m_last = m_own;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && act((m_last + k) % N)) begin
          m_own  = (m_last + k) % N;
          m_pend = 1'b1;
          found  = 1'b1;
        end
      end
    end
    if (mem_rvalid) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_orphan = 1'b1;
    end
    if (e_push) q.push_back(m_own);
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle_check();
    advance();
  endtask

  task automatic issue_read(input int r, input logic [31:0] addr);
    bit got = 1'b0;
    req_rd[r] = 1'b1;
    req_addr[r*32 +: 32] = addr;
    for (int n = 0; n < 8 && !got; n++) begin
      settle_check();
      got = req_rdy[r];
      advance();
    end
    req_rd[r] = 1'b0;
    chk("issue_read_accept", 64'(got), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_orphan", 64'(orphan_err), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  bit [N-1:0] hold;
  logic [N-1:0] acc;

  initial begin
    m_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single read from requester 1
    req_rd = 2'b10;
    req_addr[63:32] = 32'h0000_0100;
    mem_rdy = 1'b1;
    settle_check();
    chk("t1_idle_rd", 64'(mem_rd), 64'd0);
    advance();
    settle_check();
    chk("t1_mem_rd", 64'(mem_rd), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h100);
    chk("t1_req_rdy", 64'(req_rdy), 64'b10);
    advance();
    req_rd = '0;
    cycle();
    cycle();
    mem_rvalid = 1'b1;
    mem_read_data = 32'hDEAD_BEEF;
    settle_check();
    chk("t1_rvalid", 64'(req_rvalid), 64'b10);
    chk("t1_rdata", 64'(req_read_data), 64'hDEAD_BEEF);
    advance();
    mem_rvalid = 1'b0;

    // Fairness: both requesters write continuously
    req_wr = 8'hFF;
    req_write_data = {32'h2222_2222, 32'h1111_1111};
    for (int c = 0; c < 12; c++) begin
      settle_check();
      chk("t2_rr_order", 64'(req_rdy),
          (c % 2 == 0) ? 64'd0 : (((c / 2) % 2 == 0) ? 64'b01 : 64'b10));
      advance();
    end
    req_wr = '0;
    cycle();

    // Backpressure on a write from requester 0
    req_wr[3:0] = 4'b0011;
    req_write_data[31:0] = 32'h0000_1234;
    req_addr[31:0] = 32'h0000_0040;
    mem_rdy = 1'b0;
    cycle();
    for (int k = 0; k < 5; k++) begin
      settle_check();
      chk("t3_hold_wr", 64'(mem_wr), 64'b0011);
      chk("t3_hold_data", 64'(mem_write_data), 64'h1234);
      chk("t3_hold_rdy", 64'(req_rdy), 64'd0);
      advance();
    end
    mem_rdy = 1'b1;
    settle_check();
    chk("t3_accept", 64'(req_rdy), 64'b01);
    advance();
    req_wr = '0;
    settle_check();
    chk("t3_single", 64'(req_rdy), 64'd0);
    advance();

    // Outstanding limit with owners 0,1,1,0 then a held fifth read from 1
    issue_read(0, 32'h200);
    issue_read(1, 32'h300);
    issue_read(1, 32'h340);
    issue_read(0, 32'h400);
    req_rd[1] = 1'b1;
    req_addr[63:32] = 32'h0000_0500;
    cycle();
    for (int k = 0; k < 3; k++) begin
      settle_check();
      chk("t4_full_rd", 64'(mem_rd), 64'd0);
      chk("t4_full_rdy", 64'(req_rdy), 64'd0);
      advance();
    end
    mem_rvalid = 1'b1;
    mem_read_data = 32'h0000_00A0;
    settle_check();
    chk("t4_pop0", 64'(req_rvalid), 64'b01);
    chk("t4_pop_blocked", 64'(req_rdy), 64'd0);
    advance();
    mem_rvalid = 1'b0;
    settle_check();
    chk("t4_fifth_rdy", 64'(req_rdy), 64'b10);
    chk("t4_fifth_rd", 64'(mem_rd), 64'd1);
    advance();
    req_rd = '0;

    // Responses in issue order 1,1,0,1 with errors on some
    mem_rvalid = 1'b1;
    mem_error = 1'b1;
    settle_check();
    chk("t5_rv_a", 64'(req_rvalid), 64'b10);
    chk("t5_err_a", 64'(req_error), 64'b10);
    advance();
    mem_error = 1'b0;
    settle_check();
    chk("t5_rv_b", 64'(req_rvalid), 64'b10);
    chk("t5_err_b", 64'(req_error), 64'b00);
    advance();
    settle_check();
    chk("t5_rv_c", 64'(req_rvalid), 64'b01);
    advance();
    mem_error = 1'b1;
    settle_check();
    chk("t5_rv_d", 64'(req_rvalid), 64'b10);
    chk("t5_err_d", 64'(req_error), 64'b10);
    advance();
    settle_check();
    chk("t5_orphan_rv", 64'(req_rvalid), 64'd0);
    chk("t5_orphan_pre", 64'(orphan_err), 64'd0);
    advance();
    mem_rvalid = 1'b0;
    mem_error = 1'b0;
    settle_check();
    chk("t5_orphan_set", 64'(orphan_err), 64'd1);
    advance();
    cycle();
    cycle();
    settle_check();
    chk("t5_orphan_sticky", 64'(orphan_err), 64'd1);
    advance();

    // Reset while granted, with a read tag in flight
    issue_read(0, 32'h600);
    req_wr[7:4] = 4'hF;
    mem_rdy = 1'b0;
    cycle();
    settle_check();
    chk("t6_granted", 64'(mem_wr), 64'hF);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("t6_rst_wr", 64'(mem_wr), 64'd0);
    chk("t6_rst_rd", 64'(mem_rd), 64'd0);
    chk("t6_rst_addr", 64'(mem_addr), 64'd0);
    chk("t6_rst_wdata", 64'(mem_write_data), 64'd0);
    chk("t6_rst_rdy", 64'(req_rdy), 64'd0);
    chk("t6_rst_orphan", 64'(orphan_err), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_wr = 8'hFF;
    mem_rdy = 1'b1;
    cycle();
    settle_check();
    chk("t6_first_gnt", 64'(req_rdy), 64'b01);
    advance();
    req_wr = '0;
    cycle();
    mem_rvalid = 1'b1;
    settle_check();
    chk("t6_stale_rv", 64'(req_rvalid), 64'd0);
    advance();
    mem_rvalid = 1'b0;
    settle_check();
    chk("t6_stale_orphan", 64'(orphan_err), 64'd1);
    advance();

    // Randomized traffic against the model
    do_reset();
    hold = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i] && $urandom_range(0, 1) == 1) begin
          int kind;
          kind = $urandom_range(0, 2);
          req_wr[i*WL +: WL] = (kind != 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          req_rd[i] = (kind != 0);
          req_addr[i*32 +: 32] = $urandom;
          req_write_data[i*32 +: 32] = $urandom;
          hold[i] = 1'b1;
        end
      end
      mem_rdy = ($urandom_range(0, 3) != 0);
      mem_rvalid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_error = 1'($urandom_range(0, 1));
      mem_read_data = $urandom;
      settle_check();
      acc = e_rdy;
      advance();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          hold[i] = 1'b0;
          req_wr[i*WL +: WL] = '0;
          req_rd[i] = 1'b0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
